// File: rtl/mips32_mem_responder.sv
// Word-addressed data memory for the MIPS32 MEM stage: one request at a time, WAIT_CYCLES wait states (optional MEM_RESP_ERR_EN range check).
// Response appears WAIT_CYCLES+1 edges after accept; it is held until rsp_ready, and new requests are accepted only in IDLE.
module mips32_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
`ifdef MEM_RESP_ERR_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              accept;
  logic              commit;
  logic              rsp_done;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              addr_ok;
  logic              mem_wr;
  logic [31:0]       commit_dat;

  assign idx = lat_addr[IDX_W-1:0];

`ifdef MEM_RESP_ERR_EN
  assign addr_ok = ({1'b0, lat_addr} < (ADDR_W+1)'(DEPTH));
`else
  // Without the range check, upper address bits simply alias onto the array.
  assign addr_ok = 1'b1;
`endif

  assign req_ready  = (state == IDLE);
  assign mem_wr     = commit & lat_we & addr_ok;
  assign commit_dat = !addr_ok ? 32'd0 : (lat_we ? lat_wdata : mem[idx]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        // Counter spans the wait states; the edge after it reaches zero commits.
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      busy      <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= commit_dat;
`ifdef MEM_RESP_ERR_EN
        rsp_err   <= !addr_ok;
`endif
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
`ifdef MEM_RESP_ERR_EN
        rsp_err   <= 1'b0;
`endif
      end
    end
  end

  // Storage is deliberately not reset; a load on the commit edge reads the pre-write word.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx] <= lat_wdata;
    end
  end

endmodule
